// File: rtl/serializer_pkg.sv
// Shared types and helpers for word_bit_serializer and its hold buffer.
package serializer_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  function automatic int unsigned ser_cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry valid/ready holding register used as the serializer's skid slot.
module ser_hold_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             full;
  logic [WIDTH-1:0] data;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_ready) begin
      full <= 1'b0;
    end
  end

  always_comb begin
    in_ready  = !full;
    out_valid = full;
    out_data  = data;
  end

endmodule

// File: rtl/word_bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in on valid/ready, one bit per clock out.
// Define SERIALIZER_SKID_EN to add a one-entry hold buffer for gap-free back-to-back words.
module word_bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             idle
);

  localparam int unsigned    CW       = ser_cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] load_word;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic             accept;
  logic             load_en;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  always_comb begin
    sh_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    cnt_inc = cnt + CW'(1);
    accept  = in_valid && in_ready;
  end

`ifdef SERIALIZER_SKID_EN
  logic             load_slot;
  logic             hold_full;
  logic             hold_pop;
  logic             buf_ready;
  logic [WIDTH-1:0] held_data;

  // A load slot is idle or the last-bit cycle; a held word wins it, otherwise
  // an incoming word bypasses the buffer straight into the shifter.
  always_comb begin
    load_slot = (state == SER_IDLE) || (cnt == CNT_LAST);
    hold_pop  = load_slot && hold_full;
    load_en   = load_slot && (hold_full || accept);
    load_word = hold_full ? held_data : in_data;
    in_ready  = !rst && buf_ready;
    idle      = (state == SER_IDLE) && !hold_full;
  end

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid && !load_slot),
    .in_ready  (buf_ready),
    .out_data  (held_data),
    .out_valid (hold_full),
    .out_ready (hold_pop)
  );
`else
  always_comb begin
    in_ready  = !rst && (state == SER_IDLE);
    load_en   = accept;
    load_word = in_data;
    idle      = (state == SER_IDLE);
  end
`endif

  // Output registers always show bit number cnt of the word in the shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SER_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
    end else if (load_en) begin
      state     <= SER_SHIFT;
      shreg     <= load_word;
      cnt       <= '0;
      bit_out   <= lead_bit(load_word);
      bit_valid <= 1'b1;
      bit_last  <= 1'b0;
    end else if (state == SER_SHIFT) begin
      if (cnt == CNT_LAST) begin
        state     <= SER_IDLE;
        bit_out   <= 1'b0;
        bit_valid <= 1'b0;
        bit_last  <= 1'b0;
      end else begin
        shreg    <= sh_next;
        cnt      <= cnt_inc;
        bit_out  <= lead_bit(sh_next);
        bit_last <= (cnt_inc == CNT_LAST);
      end
    end
  end

endmodule
